// File: rtl/audio_mixer.sv
// audio_mixer: two-source stereo mixer with per-source volume. One multiplier is
// time-shared over a fixed six-state sequence; results are shifted and saturated.
module audio_mixer #(
  parameter int VOL_SHIFT = 7
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic signed [15:0] src0_l,
  input  logic signed [15:0] src0_r,
  input  logic signed [15:0] src1_l,
  input  logic signed [15:0] src1_r,
  input  logic        [7:0]  vol0,
  input  logic        [7:0]  vol1,
  input  logic               mute,
  input  logic               in_valid,
  output logic signed [15:0] audio_l,
  output logic signed [15:0] audio_r,
  output logic               out_valid,
  output logic               busy,
  output logic               dropped
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    M0L  = 3'd1,
    M0R  = 3'd2,
    M1L  = 3'd3,
    M1R  = 3'd4,
    SAT  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic signed [15:0] s0l_q, s0l_d, s0r_q, s0r_d, s1l_q, s1l_d, s1r_q, s1r_d;
  logic        [7:0]  v0_q, v0_d, v1_q, v1_d;
  logic               mute_q, mute_d;
  logic signed [25:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [15:0] audio_l_q, audio_l_d, audio_r_q, audio_r_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               dropped_q, dropped_d;

  logic signed [15:0] mul_a_s;
  logic signed [8:0]  mul_b_s;
  logic signed [24:0] prod_s;
  logic signed [25:0] prod_ext_s;
  logic               accept_s;

  function automatic logic signed [15:0] sat16(input logic signed [25:0] v);
    if (v > 26'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -26'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

  // Shared multiplier operand select: one product per multiply state.
  always_comb begin
    mul_a_s = 16'sd0;
    mul_b_s = 9'sd0;
    case (state_q)
      M0L:     begin mul_a_s = s0l_q; mul_b_s = {1'b0, v0_q}; end
      M0R:     begin mul_a_s = s0r_q; mul_b_s = {1'b0, v0_q}; end
      M1L:     begin mul_a_s = s1l_q; mul_b_s = {1'b0, v1_q}; end
      M1R:     begin mul_a_s = s1r_q; mul_b_s = {1'b0, v1_q}; end
      default: begin mul_a_s = 16'sd0; mul_b_s = 9'sd0; end
    endcase
    prod_s     = 25'(mul_a_s) * 25'(mul_b_s);
    prod_ext_s = 26'(prod_s);
  end

  // Sequencer, accumulation and output update.
  always_comb begin
    accept_s    = in_valid && (state_q == IDLE);
    state_d     = state_q;
    s0l_d       = s0l_q;
    s0r_d       = s0r_q;
    s1l_d       = s1l_q;
    s1r_d       = s1r_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    mute_d      = mute_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    audio_l_d   = audio_l_q;
    audio_r_d   = audio_r_q;
    out_valid_d = 1'b0;
    dropped_d   = dropped_q | (in_valid && (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          s0l_d   = src0_l;
          s0r_d   = src0_r;
          s1l_d   = src1_l;
          s1r_d   = src1_r;
          v0_d    = vol0;
          v1_d    = vol1;
          mute_d  = mute;
          state_d = M0L;
        end else begin
          state_d = IDLE;
        end
      end
      M0L: begin acc_l_d = prod_ext_s;           state_d = M0R; end
      M0R: begin acc_r_d = prod_ext_s;           state_d = M1L; end
      M1L: begin acc_l_d = acc_l_q + prod_ext_s; state_d = M1R; end
      M1R: begin acc_r_d = acc_r_q + prod_ext_s; state_d = SAT; end
      SAT: begin
        if (mute_q) begin
          audio_l_d = 16'sd0;
          audio_r_d = 16'sd0;
        end else begin
          audio_l_d = sat16(acc_l_q >>> VOL_SHIFT);
          audio_r_d = sat16(acc_r_q >>> VOL_SHIFT);
        end
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // busy stays high through the cycle the result appears, so a new strobe there sees busy=1 yet is accepted
    busy_d = (state_d != IDLE) || (state_q == SAT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      s0l_q       <= 16'sd0;
      s0r_q       <= 16'sd0;
      s1l_q       <= 16'sd0;
      s1r_q       <= 16'sd0;
      v0_q        <= 8'd0;
      v1_q        <= 8'd0;
      mute_q      <= 1'b0;
      acc_l_q     <= 26'sd0;
      acc_r_q     <= 26'sd0;
      audio_l_q   <= 16'sd0;
      audio_r_q   <= 16'sd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s0l_q       <= s0l_d;
      s0r_q       <= s0r_d;
      s1l_q       <= s1l_d;
      s1r_q       <= s1r_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      mute_q      <= mute_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      audio_l_q   <= audio_l_d;
      audio_r_q   <= audio_r_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      dropped_q   <= dropped_d;
    end
  end

  assign audio_l   = audio_l_q;
  assign audio_r   = audio_r_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_audio_mixer.sv
// Scoreboard bench for audio_mixer: directed corner cases plus randomized mixes,
// checked against an arithmetic mixing model.
module tb_audio_mixer;

  logic               clk_sys = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] src0_l = 16'sd0, src0_r = 16'sd0, src1_l = 16'sd0, src1_r = 16'sd0;
  logic        [7:0]  vol0 = 8'd0, vol1 = 8'd0;
  logic               mute = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] audio_l, audio_r;
  logic               out_valid, busy, dropped;

  audio_mixer #(.VOL_SHIFT(7)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .src0_l(src0_l), .src0_r(src0_r), .src1_l(src1_l), .src1_r(src1_r),
    .vol0(vol0), .vol1(vol1), .mute(mute), .in_valid(in_valid),
    .audio_l(audio_l), .audio_r(audio_r),
    .out_valid(out_valid), .busy(busy), .dropped(dropped)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int due;
    int l;
    int r;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   checking = 1'b0;
  int   last_acc = -100;
  int   prev_acc = -100;
  int   exp_l = 0;
  int   exp_r = 0;
  bit   exp_dropped = 1'b0;

  always @(posedge clk_sys) cyc++;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Reference: gain is vol/128, result floored toward -inf, then clamped.
  function automatic int mix(input int s0, input int s1, input int v0, input int v1, input bit m);
    int p;
    int q;
    p = s0 * v0 + s1 * v1;
    if (p >= 0) q = p / 128;
    else        q = -((-p + 127) / 128);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return m ? 0 : q;
  endfunction

  // Monitor: scoreboard pops on out_valid; busy/dropped/held outputs checked every cycle.
  always @(negedge clk_sys) begin
    if (checking) begin
      bit   exp_busy;
      exp_t e;
      exp_busy = (cyc >= last_acc + 1 && cyc <= last_acc + 6) ||
                 (cyc >= prev_acc + 1 && cyc <= prev_acc + 6);
      check("busy", int'(busy), int'(exp_busy));
      check("dropped", int'(dropped), int'(exp_dropped));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("latency_cycle", cyc, e.due);
          exp_l = e.l;
          exp_r = e.r;
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        check("missing_out_valid", cyc, e.due);
        exp_l = e.l;
        exp_r = e.r;
      end
      check("audio_l", int'(audio_l), exp_l);
      check("audio_r", int'(audio_r), exp_r);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Drive one strobe; the model decides whether the mixer is free to take it.
  task automatic send(input int s0l, input int s0r, input int s1l, input int s1r,
                      input int v0, input int v1, input bit m);
    exp_t e;
    bit   drop;
    src0_l = 16'(s0l); src0_r = 16'(s0r); src1_l = 16'(s1l); src1_r = 16'(s1r);
    vol0 = 8'(v0); vol1 = 8'(v1); mute = m; in_valid = 1'b1;
    drop = (cyc < last_acc + 6);
    if (!drop) begin
      prev_acc = last_acc;
      last_acc = cyc;
      e.due = cyc + 6;
      e.l = mix(s0l, s1l, v0, v1, m);
      e.r = mix(s0r, s1r, v0, v1, m);
      exp_q.push_back(e);
    end
    @(posedge clk_sys);
    #1;
    in_valid = 1'b0;
    src0_l = 16'($urandom); src0_r = 16'($urandom); src1_l = 16'($urandom); src1_r = 16'($urandom);
    vol0 = 8'($urandom); vol1 = 8'($urandom); mute = 1'($urandom);
    if (drop) exp_dropped = 1'b1;
  endtask

  task automatic do_reset(input bit with_strobe);
    reset = 1'b1;
    in_valid = with_strobe;
    src0_l = 16'sd5000; src1_l = 16'sd5000; vol0 = 8'd128; vol1 = 8'd128; mute = 1'b0;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    last_acc = -100;
    prev_acc = -100;
    exp_l = 0;
    exp_r = 0;
    exp_dropped = 1'b0;
  endtask

  task automatic send_random();
    int s[4];
    foreach (s[i]) s[i] = int'($signed(16'($urandom)));
    send(s[0], s[1], s[2], s[3], int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
         ($urandom_range(0, 7) == 0));
  endtask

  initial begin
    idle(2);
    reset = 1'b0;
    checking = 1'b1;
    idle(2);

    send(1000, 0, 0, 0, 128, 128, 1'b0);         idle(6);
    send(30000, -30000, 30000, -30000, 128, 128, 1'b0); idle(6);
    send(-2000, 0, 0, 0, 64, 128, 1'b0);         idle(6);
    send(-1, 0, 0, 0, 64, 128, 1'b0);            idle(6);
    send(1, 0, 0, 0, 64, 128, 1'b0);             idle(6);
    send(12345, -2222, 1000, 500, 200, 100, 1'b1); idle(6);
    send(20000, -100, 32767, -32768, 255, 0, 1'b0); idle(6);
    send(-300, 300, -32768, 32767, 255, 255, 1'b0); idle(6);

    // strobe at N+3 dropped, strobe at N+6 accepted
    send(4000, -4000, 100, -100, 100, 50, 1'b0);
    idle(2);
    send(7777, 7777, 7777, 7777, 255, 255, 1'b0);
    idle(2);
    send(-4000, 4000, 0, 0, 128, 128, 1'b0);
    idle(8);

    for (int i = 0; i < 20; i++) begin
      send_random();
      idle(5);
    end
    for (int i = 0; i < 40; i++) begin
      send_random();
      idle(int'($urandom_range(0, 8)));
    end
    idle(8);

    // reset mid-mix aborts and clears the sticky drop flag
    send(9000, 9000, 9000, 9000, 128, 128, 1'b0);
    send(1, 1, 1, 1, 1, 1, 1'b0);
    idle(1);
    do_reset(1'b0);
    idle(10);

    do_reset(1'b1);
    idle(10);

    send(-1000, 1000, 500, -500, 128, 128, 1'b0);
    idle(10);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
